// File: rtl/stopwatch_core.sv
// Stopwatch/countdown timekeeping core: prescaler, cascaded msec/sec/min counters,
// STOP/RUN/DONE control with lap freeze and one-cycle done/wrap flags.
module stopwatch_core #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int TICK_HZ  = 100,
    parameter int MSEC_MOD = 100,
    parameter int SEC_MOD  = 60,
    parameter int MIN_MOD  = 60,
    localparam int MW  = $clog2(MSEC_MOD),
    localparam int SW  = $clog2(SEC_MOD),
    localparam int MNW = $clog2(MIN_MOD)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           i_run_stop,
    input  logic           i_clear,
    input  logic           i_lap,
    input  logic           i_mode,
    input  logic [MNW-1:0] i_preset_min,
    input  logic [SW-1:0]  i_preset_sec,
    output logic [MW-1:0]  o_msec,
    output logic [SW-1:0]  o_sec,
    output logic [MNW-1:0] o_min,
    output logic           o_running,
    output logic           o_lap_hold,
    output logic           o_done,
    output logic           o_wrap
);
    localparam int DIV = CLK_FREQ / TICK_HZ;
    localparam int PW  = $clog2(DIV);
    localparam logic [PW-1:0]  PRESC_MAX = PW'(DIV - 1);
    localparam logic [MW-1:0]  MSEC_MAX  = MW'(MSEC_MOD - 1);
    localparam logic [SW-1:0]  SEC_MAX   = SW'(SEC_MOD - 1);
    localparam logic [MNW-1:0] MIN_MAX   = MNW'(MIN_MOD - 1);

    typedef enum logic [1:0] {ST_STOP, ST_RUN, ST_DONE} state_t;

    function automatic logic [SW-1:0] sat_sec(input logic [SW-1:0] v);
        return (v > SEC_MAX) ? SEC_MAX : v;
    endfunction

    function automatic logic [MNW-1:0] sat_min(input logic [MNW-1:0] v);
        return (v > MIN_MAX) ? MIN_MAX : v;
    endfunction

    state_t         state_q, state_d;
    logic           mode_q, mode_d;
    logic [PW-1:0]  presc_q, presc_d;
    logic [MW-1:0]  msec_q, msec_d, snap_msec_q, snap_msec_d;
    logic [SW-1:0]  sec_q, sec_d, snap_sec_q, snap_sec_d;
    logic [MNW-1:0] min_q, min_d, snap_min_q, snap_min_d;
    logic           hold_q, hold_d, done_q, done_d, wrap_q, wrap_d;

    logic           clr_p, rs_p, lap_p, reload, count_zero;
    logic [MW-1:0]  stp_msec;
    logic [SW-1:0]  stp_sec;
    logic [MNW-1:0] stp_min;
    logic           stp_wrap, stp_zero;

    // Clear outranks run_stop, which outranks lap; dropped pulses have no effect.
    assign clr_p      = i_clear;
    assign rs_p       = i_run_stop & ~i_clear;
    assign lap_p      = i_lap & ~i_clear & ~i_run_stop;
    assign count_zero = (msec_q == '0) && (sec_q == '0) && (min_q == '0);

    // One count step in the current direction, with full carry/borrow cascade.
    always_comb begin
        stp_msec = msec_q;
        stp_sec  = sec_q;
        stp_min  = min_q;
        stp_wrap = 1'b0;
        if (!mode_q) begin
            if (msec_q == MSEC_MAX) begin
                stp_msec = '0;
                if (sec_q == SEC_MAX) begin
                    stp_sec = '0;
                    if (min_q == MIN_MAX) begin
                        stp_min  = '0;
                        stp_wrap = 1'b1;
                    end else begin
                        stp_min = min_q + 1'b1;
                    end
                end else begin
                    stp_sec = sec_q + 1'b1;
                end
            end else begin
                stp_msec = msec_q + 1'b1;
            end
        end else begin
            if (msec_q != '0) begin
                stp_msec = msec_q - 1'b1;
            end else begin
                stp_msec = MSEC_MAX;
                if (sec_q != '0) begin
                    stp_sec = sec_q - 1'b1;
                end else begin
                    stp_sec = SEC_MAX;
                    stp_min = min_q - 1'b1;
                end
            end
        end
    end

    assign stp_zero = (stp_msec == '0) && (stp_sec == '0) && (stp_min == '0);

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        presc_d     = presc_q;
        msec_d      = msec_q;
        sec_d       = sec_q;
        min_d       = min_q;
        snap_msec_d = snap_msec_q;
        snap_sec_d  = snap_sec_q;
        snap_min_d  = snap_min_q;
        hold_d      = hold_q;
        done_d      = 1'b0;
        wrap_d      = 1'b0;
        reload      = 1'b0;
        case (state_q)
            ST_STOP: begin
                if (clr_p) begin
                    reload = 1'b1;
                end else if (rs_p) begin
                    if (!(mode_q && count_zero)) state_d = ST_RUN;
                end else if (lap_p) begin
                    hold_d = 1'b0;
                end
            end
            ST_RUN: begin
                // Stopping freezes the prescaler so a pause loses no sub-tick time.
                if (rs_p) begin
                    state_d = ST_STOP;
                end else begin
                    if (lap_p) begin
                        if (!hold_q) begin
                            snap_msec_d = msec_q;
                            snap_sec_d  = sec_q;
                            snap_min_d  = min_q;
                            hold_d      = 1'b1;
                        end else begin
                            hold_d = 1'b0;
                        end
                    end
                    if (presc_q == PRESC_MAX) begin
                        presc_d = '0;
                        msec_d  = stp_msec;
                        sec_d   = stp_sec;
                        min_d   = stp_min;
                        wrap_d  = stp_wrap;
                        if (mode_q && stp_zero) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (clr_p) begin
                    reload = 1'b1;
                end else if (lap_p) begin
                    hold_d = 1'b0;
                end
            end
            default: state_d = ST_STOP;
        endcase
        if (reload) begin
            state_d = ST_STOP;
            mode_d  = i_mode;
            presc_d = '0;
            hold_d  = 1'b0;
            msec_d  = '0;
            sec_d   = i_mode ? sat_sec(i_preset_sec) : '0;
            min_d   = i_mode ? sat_min(i_preset_min) : '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_STOP;
            mode_q      <= 1'b0;
            presc_q     <= '0;
            msec_q      <= '0;
            sec_q       <= '0;
            min_q       <= '0;
            snap_msec_q <= '0;
            snap_sec_q  <= '0;
            snap_min_q  <= '0;
            hold_q      <= 1'b0;
            done_q      <= 1'b0;
            wrap_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            presc_q     <= presc_d;
            msec_q      <= msec_d;
            sec_q       <= sec_d;
            min_q       <= min_d;
            snap_msec_q <= snap_msec_d;
            snap_sec_q  <= snap_sec_d;
            snap_min_q  <= snap_min_d;
            hold_q      <= hold_d;
            done_q      <= done_d;
            wrap_q      <= wrap_d;
        end
    end

    assign o_msec     = hold_q ? snap_msec_q : msec_q;
    assign o_sec      = hold_q ? snap_sec_q  : sec_q;
    assign o_min      = hold_q ? snap_min_q  : min_q;
    assign o_running  = (state_q == ST_RUN);
    assign o_lap_hold = hold_q;
    assign o_done     = done_q;
    assign o_wrap     = wrap_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Bench for stopwatch_core: tick-count reference model compared every cycle,
// directed scenarios with literal expectations, then randomized pulse traffic.
module tb_stopwatch_core;
    localparam int CLK_FREQ = 1000;
    localparam int TICK_HZ  = 100;
    localparam int MSEC_MOD = 4;
    localparam int SEC_MOD  = 3;
    localparam int MIN_MOD  = 2;
    localparam int DIV      = CLK_FREQ / TICK_HZ;
    localparam int PERIOD   = MSEC_MOD * SEC_MOD * MIN_MOD;
    localparam int MW       = $clog2(MSEC_MOD);
    localparam int SW       = $clog2(SEC_MOD);
    localparam int MNW      = $clog2(MIN_MOD);

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           i_run_stop = 1'b0, i_clear = 1'b0, i_lap = 1'b0, i_mode = 1'b0;
    logic [MNW-1:0] i_preset_min = '0;
    logic [SW-1:0]  i_preset_sec = '0;
    logic [MW-1:0]  o_msec;
    logic [SW-1:0]  o_sec;
    logic [MNW-1:0] o_min;
    logic           o_running, o_lap_hold, o_done, o_wrap;

    int n_checks = 0;
    int n_fail   = 0;

    stopwatch_core #(
        .CLK_FREQ(CLK_FREQ), .TICK_HZ(TICK_HZ),
        .MSEC_MOD(MSEC_MOD), .SEC_MOD(SEC_MOD), .MIN_MOD(MIN_MOD)
    ) dut (
        .clk(clk), .reset(reset),
        .i_run_stop(i_run_stop), .i_clear(i_clear), .i_lap(i_lap), .i_mode(i_mode),
        .i_preset_min(i_preset_min), .i_preset_sec(i_preset_sec),
        .o_msec(o_msec), .o_sec(o_sec), .o_min(o_min),
        .o_running(o_running), .o_lap_hold(o_lap_hold),
        .o_done(o_done), .o_wrap(o_wrap)
    );

    initial forever #5 clk = ~clk;

    // Count kept as a single number of elapsed ticks; state 0=STOP 1=RUN 2=DONE.
    typedef struct packed {
        int st; int mode; int presc; int t; int hold; int snap; int done; int wrap;
    } mstate_t;

    mstate_t m = '0;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic mstate_t model_next(input mstate_t c, input logic rs, input logic clr,
                                           input logic lap, input logic md, input int pm, input int ps);
        mstate_t n = c;
        bit r = rs && !clr;
        bit l = lap && !clr && !rs;
        bit do_reload = 0;
        n.done = 0;
        n.wrap = 0;
        case (c.st)
            0: begin
                if (clr) do_reload = 1;
                else if (r) begin
                    if (!(c.mode == 1 && c.t == 0)) n.st = 1;
                end else if (l) n.hold = 0;
            end
            1: begin
                if (r) n.st = 0;
                else begin
                    if (l) begin
                        if (c.hold == 0) begin
                            n.snap = c.t;
                            n.hold = 1;
                        end else n.hold = 0;
                    end
                    if (c.presc == DIV - 1) begin
                        n.presc = 0;
                        if (c.mode == 0) begin
                            n.t = (c.t + 1) % PERIOD;
                            n.wrap = (n.t == 0) ? 1 : 0;
                        end else begin
                            n.t = c.t - 1;
                            if (n.t == 0) begin
                                n.st = 2;
                                n.done = 1;
                            end
                        end
                    end else n.presc = c.presc + 1;
                end
            end
            default: begin
                if (clr) do_reload = 1;
                else if (l) n.hold = 0;
            end
        endcase
        if (do_reload) begin
            n.st = 0;
            n.mode = md ? 1 : 0;
            n.presc = 0;
            n.hold = 0;
            n.t = md ? (imin(pm, MIN_MOD - 1) * MSEC_MOD * SEC_MOD + imin(ps, SEC_MOD - 1) * MSEC_MOD) : 0;
        end
        return n;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk or negedge reset);
        if (!reset) m = '0;
        else m = model_next(m, i_run_stop, i_clear, i_lap, i_mode, int'(i_preset_min), int'(i_preset_sec));
    end

    initial forever begin
        int disp;
        @(negedge clk);
        disp = (m.hold != 0) ? m.snap : m.t;
        check("msec",     int'(o_msec),     disp % MSEC_MOD);
        check("sec",      int'(o_sec),      (disp / MSEC_MOD) % SEC_MOD);
        check("min",      int'(o_min),      disp / (MSEC_MOD * SEC_MOD));
        check("running",  int'(o_running),  (m.st == 1) ? 1 : 0);
        check("lap_hold", int'(o_lap_hold), m.hold);
        check("done",     int'(o_done),     m.done);
        check("wrap",     int'(o_wrap),     m.wrap);
    end

    task automatic step(input logic rs, input logic clr, input logic lap);
        i_run_stop = rs;
        i_clear    = clr;
        i_lap      = lap;
        @(posedge clk);
        #1;
        i_run_stop = 1'b0;
        i_clear    = 1'b0;
        i_lap      = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic expect_disp(input string name, input int mn, input int s, input int ms);
        check({name, "_min"},  int'(o_min),  mn);
        check({name, "_sec"},  int'(o_sec),  s);
        check({name, "_msec"}, int'(o_msec), ms);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        expect_disp("reset", 0, 0, 0);
        check("reset_running", int'(o_running), 0);
        check("reset_done_wrap", int'({o_done, o_wrap, o_lap_hold}), 0);
        reset = 1'b1;

        // Up count, carry into seconds, then full wrap.
        i_mode = 1'b0;
        step(0, 1, 0);
        step(1, 0, 0);
        idle(40);
        expect_disp("up40", 0, 1, 0);
        check("up40_running", int'(o_running), 1);
        idle(199);
        expect_disp("allmax", 1, 2, 3);
        check("allmax_wrap", int'(o_wrap), 0);
        idle(1);
        expect_disp("wrapped", 0, 0, 0);
        check("wrap_pulse", int'(o_wrap), 1);
        idle(1);
        check("wrap_one_cycle", int'(o_wrap), 0);

        // Pause with the prescaler at 5, resume: step lands after 5 RUN cycles.
        idle(4);
        step(1, 0, 0);
        check("paused_running", int'(o_running), 0);
        idle(50);
        step(1, 0, 0);
        idle(4);
        check("resume_4clk_msec", int'(o_msec), 0);
        idle(1);
        check("resume_5clk_msec", int'(o_msec), 1);

        // Lap freeze at 0:1.2, internal count keeps going, second lap shows live count.
        idle(50);
        expect_disp("prelap", 0, 1, 2);
        step(0, 0, 1);
        check("lap_hold_on", int'(o_lap_hold), 1);
        idle(30);
        expect_disp("frozen", 0, 1, 2);
        step(0, 0, 1);
        check("lap_hold_off", int'(o_lap_hold), 0);
        expect_disp("live", 0, 2, 1);

        // Clear and run_stop together in STOP: only the clear acts.
        step(1, 0, 0);
        step(1, 1, 0);
        check("clr_rs_running", int'(o_running), 0);
        expect_disp("clr_rs", 0, 0, 0);

        // Countdown from 0:1.0.
        i_mode = 1'b1;
        i_preset_min = '0;
        i_preset_sec = SW'(1);
        step(0, 1, 0);
        expect_disp("down_load", 0, 1, 0);
        step(1, 0, 0);
        idle(39);
        expect_disp("down_3tick", 0, 0, 1);
        idle(1);
        expect_disp("down_zero", 0, 0, 0);
        check("done_pulse", int'(o_done), 1);
        check("done_running", int'(o_running), 0);
        idle(1);
        check("done_one_cycle", int'(o_done), 0);
        step(1, 0, 0);
        check("done_rs_ignored", int'(o_running), 0);
        step(0, 1, 0);
        expect_disp("done_reload", 0, 1, 0);

        // Preset saturation and a zero preset that cannot start.
        i_preset_min = MNW'(1);
        i_preset_sec = SW'(3);
        step(0, 1, 0);
        expect_disp("sat", 1, 2, 0);
        i_preset_min = '0;
        i_preset_sec = '0;
        step(0, 1, 0);
        step(1, 0, 0);
        check("zero_start_ignored", int'(o_running), 0);
        idle(3);

        // Randomized pulse traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            i_mode       = 1'($urandom_range(0, 1));
            i_preset_min = MNW'($urandom_range(0, MIN_MOD - 1));
            i_preset_sec = SW'($urandom_range(0, 3));
            step($urandom_range(0, 49) == 0, $urandom_range(0, 89) == 0, $urandom_range(0, 24) == 0);
        end

        // Asynchronous reset between edges in the middle of a run.
        i_mode = 1'b0;
        step(0, 1, 0);
        step(1, 0, 0);
        idle(25);
        #2;
        reset = 1'b0;
        #1;
        expect_disp("async_rst", 0, 0, 0);
        check("async_rst_running", int'(o_running), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        step(1, 0, 0);
        check("after_rst_start", int'(o_running), 1);
        idle(12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
